// File: rtl/prog_counter.sv
// prog_counter: program counter for the 1024-word program ROM, with an
// optional internal return stack for CALL/RET.
//
// Build option: define PROG_COUNTER_RSTACK_EN to compile in the internal
// return stack. Without it, mux select 01 takes the external FROM_STACK
// port and the stack status outputs are tied off.
//
// PC_COUNT is a plain register; the ROM adds its own read latency.
// Update priority each cycle is RST, HOLD, PC_LD, PC_INC, else hold.

module prog_counter #(
    parameter int                ADDR_W      = 10,
    parameter int                STACK_DEPTH = 8,
    parameter logic [ADDR_W-1:0] INTR_VEC    = 10'h3FF
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          PC_LD,
    input  logic                          PC_INC,
    input  logic [1:0]                    PC_MUX_SEL,
    input  logic [ADDR_W-1:0]             FROM_IMMED,
    input  logic [ADDR_W-1:0]             FROM_STACK,
    input  logic                          HOLD,
    input  logic                          CALL_PUSH,
    input  logic                          RET_POP,
    output logic [ADDR_W-1:0]             PC_COUNT,
    output logic [$clog2(STACK_DEPTH):0]  RS_DEPTH,
    output logic                          RS_FULL,
    output logic                          RS_EMPTY,
    output logic                          RS_OVF,
    output logic                          RS_UNF
);

    // Address presented on mux select 01 (internal top-of-stack or external port)
    logic [ADDR_W-1:0] stack_src;
    logic [ADDR_W-1:0] mux_pc;

`ifdef PROG_COUNTER_RSTACK_EN

    localparam int PTR_W   = $clog2(STACK_DEPTH);
    localparam int DEPTH_W = PTR_W + 1;

    logic [ADDR_W-1:0]  stack_mem [STACK_DEPTH];
    logic [DEPTH_W-1:0] depth_q;
    logic               ovf_q;
    logic               unf_q;
    logic               stack_full;
    logic               stack_empty;
    logic [PTR_W-1:0]   top_idx;
    logic [PTR_W-1:0]   push_idx;
    logic [ADDR_W-1:0]  pc_plus1;
    logic               do_push;
    logic               unused_from_stack;

    // The external return-address port has no role when the stack is internal
    assign unused_from_stack = ^FROM_STACK;

    assign stack_full  = (depth_q == DEPTH_W'(STACK_DEPTH));
    assign stack_empty = (depth_q == '0);
    assign top_idx     = PTR_W'(depth_q - DEPTH_W'(1));
    assign push_idx    = PTR_W'(depth_q);
    assign pc_plus1    = PC_COUNT + ADDR_W'(1);

    // A push that coincides with a pop is discarded; a push when full is dropped
    assign do_push = !RST && !HOLD && CALL_PUSH && !RET_POP && !stack_full;

    // Top entry is read combinationally so a pop and a load in one cycle
    // lands on the address being popped; an empty stack reads as zero
    assign stack_src = stack_empty ? '0 : stack_mem[top_idx];

    // Stack storage: written with the return address, never cleared
    always_ff @(posedge CLK) begin
        if (do_push)
            stack_mem[push_idx] <= pc_plus1;
    end

    // Occupancy and sticky error flags; pop takes precedence over push
    always_ff @(posedge CLK) begin
        if (RST) begin
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else if (!HOLD) begin
            if (RET_POP) begin
                if (stack_empty)
                    unf_q <= 1'b1;
                else
                    depth_q <= depth_q - DEPTH_W'(1);
            end else if (CALL_PUSH) begin
                if (stack_full)
                    ovf_q <= 1'b1;
                else
                    depth_q <= depth_q + DEPTH_W'(1);
            end
        end
    end

    assign RS_DEPTH = depth_q;
    assign RS_FULL  = stack_full;
    assign RS_EMPTY = stack_empty;
    assign RS_OVF   = ovf_q;
    assign RS_UNF   = unf_q;

`else

    logic unused_stack_ctrl;

    // Without the internal stack the push/pop strobes are ignored
    assign unused_stack_ctrl = CALL_PUSH ^ RET_POP;

    assign stack_src = FROM_STACK;

    assign RS_DEPTH = '0;
    assign RS_FULL  = 1'b0;
    assign RS_EMPTY = 1'b1;
    assign RS_OVF   = 1'b0;
    assign RS_UNF   = 1'b0;

`endif

    // Load-source selection for the next PC
    always_comb begin
        mux_pc = '0;
        case (PC_MUX_SEL)
            2'b00:   mux_pc = FROM_IMMED;
            2'b01:   mux_pc = stack_src;
            2'b10:   mux_pc = INTR_VEC;
            default: mux_pc = '0;
        endcase
    end

    // PC register: reset, stall, load, increment (wraps), else hold
    always_ff @(posedge CLK) begin
        if (RST)
            PC_COUNT <= '0;
        else if (HOLD)
            PC_COUNT <= PC_COUNT;
        else if (PC_LD)
            PC_COUNT <= mux_pc;
        else if (PC_INC)
            PC_COUNT <= PC_COUNT + ADDR_W'(1);
    end

endmodule

// File: tb/tb_prog_counter.sv
// tb_prog_counter: self-checking bench for prog_counter.
// A queue-based model tracks the PC and return stack; outputs are compared
// against it every negative clock edge, with literal checks at key points.
// Honours PROG_COUNTER_RSTACK_EN the same way the design does.

module tb_prog_counter;

    localparam int ADDR_W      = 10;
    localparam int STACK_DEPTH = 8;
    localparam int ADDR_MASK   = (1 << ADDR_W) - 1;
    localparam int INTR_ADDR   = 'h3FF;
`ifdef PROG_COUNTER_RSTACK_EN
    localparam bit HAS_STACK = 1'b1;
`else
    localparam bit HAS_STACK = 1'b0;
`endif

    logic              CLK;
    logic              RST;
    logic              PC_LD;
    logic              PC_INC;
    logic [1:0]        PC_MUX_SEL;
    logic [ADDR_W-1:0] FROM_IMMED;
    logic [ADDR_W-1:0] FROM_STACK;
    logic              HOLD;
    logic              CALL_PUSH;
    logic              RET_POP;
    logic [ADDR_W-1:0] PC_COUNT;
    logic [3:0]        RS_DEPTH;
    logic              RS_FULL;
    logic              RS_EMPTY;
    logic              RS_OVF;
    logic              RS_UNF;

    int tests_run = 0;
    int tests_failed = 0;

    // Model state
    bit model_valid = 1'b0;
    int m_pc = 0;
    int m_stack[$];
    bit m_ovf = 1'b0;
    bit m_unf = 1'b0;
    int m_top;
    int m_next;

    prog_counter #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH),
        .INTR_VEC    (10'h3FF)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .PC_LD      (PC_LD),
        .PC_INC     (PC_INC),
        .PC_MUX_SEL (PC_MUX_SEL),
        .FROM_IMMED (FROM_IMMED),
        .FROM_STACK (FROM_STACK),
        .HOLD       (HOLD),
        .CALL_PUSH  (CALL_PUSH),
        .RET_POP    (RET_POP),
        .PC_COUNT   (PC_COUNT),
        .RS_DEPTH   (RS_DEPTH),
        .RS_FULL    (RS_FULL),
        .RS_EMPTY   (RS_EMPTY),
        .RS_OVF     (RS_OVF),
        .RS_UNF     (RS_UNF)
    );

    // Free-running clock
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check_output(input string name, input int actual, input int expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, then return just after the clock edge
    task automatic apply_stimulus(input bit rst, input bit hold, input bit ld, input bit inc,
                                  input logic [1:0] sel, input int immed, input int fstack,
                                  input bit push, input bit pop);
        RST        = rst;
        HOLD       = hold;
        PC_LD      = ld;
        PC_INC     = inc;
        PC_MUX_SEL = sel;
        FROM_IMMED = ADDR_W'(immed);
        FROM_STACK = ADDR_W'(fstack);
        CALL_PUSH  = push;
        RET_POP    = pop;
        @(posedge CLK);
        #1;
    endtask

    // Behavioural model: applies the architectural rules once per rising edge
    always @(posedge CLK) begin
        if (RST) begin
            m_pc  = 0;
            m_stack.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            model_valid = 1'b1;
        end else if (!HOLD) begin
            if (HAS_STACK)
                m_top = (m_stack.size() == 0) ? 0 : m_stack[$];
            else
                m_top = int'(FROM_STACK);
            m_next = m_pc;
            if (PC_LD) begin
                case (PC_MUX_SEL)
                    2'b00:   m_next = int'(FROM_IMMED);
                    2'b01:   m_next = m_top;
                    2'b10:   m_next = INTR_ADDR;
                    default: m_next = 0;
                endcase
            end else if (PC_INC) begin
                m_next = (m_pc + 1) & ADDR_MASK;
            end
            if (HAS_STACK) begin
                if (RET_POP) begin
                    if (m_stack.size() == 0) m_unf = 1'b1;
                    else void'(m_stack.pop_back());
                end else if (CALL_PUSH) begin
                    if (m_stack.size() == STACK_DEPTH) m_ovf = 1'b1;
                    else m_stack.push_back((m_pc + 1) & ADDR_MASK);
                end
            end
            m_pc = m_next;
        end
    end

    // Compare every cycle once the model has seen a reset
    always @(negedge CLK) begin
        if (model_valid) begin
            check_output("pc_count", int'(PC_COUNT), m_pc);
            check_output("rs_depth", int'(RS_DEPTH), m_stack.size());
            check_output("rs_full",  int'(RS_FULL),  int'(m_stack.size() == STACK_DEPTH));
            check_output("rs_empty", int'(RS_EMPTY), int'(m_stack.size() == 0));
            check_output("rs_ovf",   int'(RS_OVF),   int'(m_ovf));
            check_output("rs_unf",   int'(RS_UNF),   int'(m_unf));
        end
    end

    initial begin
        RST = 1'b1; HOLD = 1'b0; PC_LD = 1'b0; PC_INC = 1'b0; PC_MUX_SEL = 2'b00;
        FROM_IMMED = '0; FROM_STACK = '0; CALL_PUSH = 1'b0; RET_POP = 1'b0;

        // Reset state
        apply_stimulus(1, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        check_output("reset_pc", int'(PC_COUNT), 'h000);
        check_output("reset_depth", int'(RS_DEPTH), 0);
        check_output("reset_empty", int'(RS_EMPTY), 1);
        check_output("reset_full", int'(RS_FULL), 0);

        // Increment sequence
        apply_stimulus(0, 0, 0, 1, 2'b00, 0, 0, 0, 0);
        check_output("inc1", int'(PC_COUNT), 'h001);
        apply_stimulus(0, 0, 0, 1, 2'b00, 0, 0, 0, 0);
        check_output("inc2", int'(PC_COUNT), 'h002);
        apply_stimulus(0, 0, 0, 1, 2'b00, 0, 0, 0, 0);
        check_output("inc3", int'(PC_COUNT), 'h003);

        // Wrap at the top of the address space
        apply_stimulus(0, 0, 1, 0, 2'b00, 'h3FF, 0, 0, 0);
        check_output("load_3ff", int'(PC_COUNT), 'h3FF);
        apply_stimulus(0, 0, 0, 1, 2'b00, 0, 0, 0, 0);
        check_output("wrap", int'(PC_COUNT), 'h000);

        // Load beats increment; then interrupt vector, then zero
        apply_stimulus(0, 0, 1, 1, 2'b00, 'h155, 0, 0, 0);
        check_output("ld_over_inc", int'(PC_COUNT), 'h155);
        apply_stimulus(0, 0, 1, 0, 2'b10, 'h155, 0, 0, 0);
        check_output("intr_vec", int'(PC_COUNT), 'h3FF);
        apply_stimulus(0, 0, 1, 0, 2'b11, 'h155, 0, 0, 0);
        check_output("sel_zero", int'(PC_COUNT), 'h000);

        // Stall freezes everything; reset overrides the stall
        apply_stimulus(0, 0, 1, 0, 2'b00, 'h055, 0, 0, 0);
        apply_stimulus(0, 1, 1, 1, 2'b00, 'h222, 0, 1, 0);
        check_output("hold_pc", int'(PC_COUNT), 'h055);
        check_output("hold_depth", int'(RS_DEPTH), 0);
        apply_stimulus(0, 1, 0, 1, 2'b00, 0, 0, 0, 1);
        check_output("hold_pop_pc", int'(PC_COUNT), 'h055);
        apply_stimulus(1, 1, 1, 1, 2'b00, 'h222, 0, 1, 0);
        check_output("rst_over_hold", int'(PC_COUNT), 'h000);

`ifdef PROG_COUNTER_RSTACK_EN
        // Call and return
        apply_stimulus(0, 0, 1, 0, 2'b00, 'h020, 0, 0, 0);
        apply_stimulus(0, 0, 1, 0, 2'b00, 'h100, 0, 1, 0);
        check_output("call_pc", int'(PC_COUNT), 'h100);
        check_output("call_depth", int'(RS_DEPTH), 1);
        apply_stimulus(0, 0, 1, 0, 2'b01, 0, 0, 0, 1);
        check_output("ret_pc", int'(PC_COUNT), 'h021);
        check_output("ret_depth", int'(RS_DEPTH), 0);

        // Push with pop in the same cycle performs only the pop
        apply_stimulus(0, 0, 0, 0, 2'b00, 0, 0, 1, 0);
        apply_stimulus(0, 0, 0, 0, 2'b00, 0, 0, 1, 1);
        check_output("pushpop_depth", int'(RS_DEPTH), 0);
        check_output("pushpop_ovf", int'(RS_OVF), 0);

        // Fill past capacity with distinct return addresses
        apply_stimulus(0, 0, 1, 0, 2'b00, 'h040, 0, 0, 0);
        for (int i = 0; i < 9; i++)
            apply_stimulus(0, 0, 0, 1, 2'b00, 0, 0, 1, 0);
        check_output("ovf_full", int'(RS_FULL), 1);
        check_output("ovf_flag", int'(RS_OVF), 1);
        check_output("ovf_depth", int'(RS_DEPTH), 8);
        check_output("ovf_pc", int'(PC_COUNT), 'h049);

        // Drain past empty, loading each popped address
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(0, 0, 1, 0, 2'b01, 0, 0, 0, 1);
            check_output("pop_addr", int'(PC_COUNT), 'h048 - i);
        end
        apply_stimulus(0, 0, 1, 0, 2'b01, 0, 0, 0, 1);
        check_output("unf_pc", int'(PC_COUNT), 'h000);
        check_output("unf_flag", int'(RS_UNF), 1);
        check_output("unf_depth", int'(RS_DEPTH), 0);
        check_output("unf_ovf_sticky", int'(RS_OVF), 1);

        // Reset clears the sticky flags
        apply_stimulus(1, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        check_output("rst_clr_ovf", int'(RS_OVF), 0);
        check_output("rst_clr_unf", int'(RS_UNF), 0);
`else
        // External return address and ignored stack strobes
        apply_stimulus(0, 0, 1, 0, 2'b01, 0, 'h0AB, 0, 0);
        check_output("ext_stack_pc", int'(PC_COUNT), 'h0AB);
        apply_stimulus(0, 0, 0, 0, 2'b00, 0, 0, 1, 0);
        check_output("nostack_depth", int'(RS_DEPTH), 0);
        check_output("nostack_empty", int'(RS_EMPTY), 1);
        apply_stimulus(0, 0, 1, 0, 2'b01, 0, 'h2CD, 0, 1);
        check_output("ext_stack_pc2", int'(PC_COUNT), 'h2CD);
        check_output("nostack_unf", int'(RS_UNF), 0);
`endif

        // Mixed traffic, checked against the model each cycle
        for (int i = 0; i < 200; i++) begin
            apply_stimulus(($urandom_range(0, 40) == 0), ($urandom_range(0, 5) == 0),
                           1'($urandom), 1'($urandom), 2'($urandom),
                           int'($urandom_range(0, ADDR_MASK)), int'($urandom_range(0, ADDR_MASK)),
                           1'($urandom), ($urandom_range(0, 3) == 0));
        end

        @(negedge CLK);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/prog_counter.md
PROG_COUNTER -- requirements
Module: prog_counter

Interface
REQ-001 Parameter ADDR_W, default 10: program address width, matching the 1024-word program ROM.
REQ-002 Parameter STACK_DEPTH, default 8: entries in the internal return stack; a power of two, at least 2.
REQ-003 Parameter INTR_VEC, default 10'h3FF: interrupt vector address.
REQ-004 CLK  in  1  rising-edge clock, shared with the program ROM.
REQ-005 RST  in  1  synchronous, active-high reset.
REQ-006 PC_LD  in  1  load the next PC from the mux.
REQ-007 PC_INC  in  1  increment the PC.
REQ-008 PC_MUX_SEL  in  2  load source: 00 FROM_IMMED; 01 stack; 10 INTR_VEC; 11 zero.
REQ-009 FROM_IMMED  in  ADDR_W  branch or call target.
REQ-010 FROM_STACK  in  ADDR_W  external return address; used only when the macro is absent.
REQ-011 HOLD  in  1  freeze all state (stall).
REQ-012 CALL_PUSH  in  1  push the return address onto the internal stack.
REQ-013 RET_POP  in  1  pop the internal stack.
REQ-014 PC_COUNT  out  ADDR_W  registered PC; drives the ROM address input.
REQ-015 RS_DEPTH  out  $clog2(STACK_DEPTH)+1  stack occupancy.
REQ-016 RS_FULL, RS_EMPTY  out  1 each  stack status.
REQ-017 RS_OVF, RS_UNF  out  1 each  sticky error flags.

Function
REQ-018 PC_COUNT SHALL be a register updated only on the rising edge of CLK; the ROM adds its own one-cycle read latency.
REQ-019 Update priority SHALL be, per cycle: RST, then HOLD, then PC_LD, then PC_INC, otherwise hold the value.
REQ-020 When HOLD=1 and RST=0, PC_COUNT, the stack contents, RS_DEPTH and the sticky flags SHALL all be unchanged, whatever PC_LD, PC_INC, CALL_PUSH or RET_POP are.
REQ-021 PC_LD=1 SHALL load the source selected by PC_MUX_SEL; a PC_INC in the same cycle SHALL be ignored.
REQ-022 PC_INC SHALL add 1 modulo 2^ADDR_W, so 0x3FF wraps to 0x000 with no flag.
REQ-023 PC_MUX_SEL=11 SHALL load 0x000.
REQ-024 RS_FULL SHALL equal (RS_DEPTH==STACK_DEPTH) and RS_EMPTY SHALL equal (RS_DEPTH==0), both combinational from the occupancy count.

Reset
REQ-025 On RST=1 at a clock edge: PC_COUNT=0x000, RS_DEPTH=0, RS_OVF=0, RS_UNF=0, giving RS_EMPTY=1 and RS_FULL=0.
REQ-026 Reset SHALL override HOLD and any push, pop or load in the same cycle, and SHALL abandon a stack operation in progress; stack RAM contents need not be cleared.

Configuration
REQ-027 Macro PROG_COUNTER_RSTACK_EN SHALL compile the internal return stack in or out.
REQ-028 With the macro defined, CALL_PUSH (HOLD=0) SHALL write PC_COUNT+1 (mod 2^ADDR_W) to the top of stack and increment RS_DEPTH.
REQ-029 With the macro defined, RET_POP (HOLD=0) SHALL decrement RS_DEPTH; PC_MUX_SEL=01 SHALL select the current top entry, combinationally, so that PC_LD with RET_POP loads the popped address in the same cycle.
REQ-030 With the macro defined, a push when full SHALL be dropped, leaving the stack unchanged and setting RS_OVF.
REQ-031 With the macro defined, a pop when empty SHALL leave RS_DEPTH at 0 and set RS_UNF; sel 01 then selects 0x000.
REQ-032 With the macro defined, CALL_PUSH and RET_POP together SHALL perform the pop only; the push is ignored and no flag is set.
REQ-033 Without the macro: sel 01 SHALL select the FROM_STACK port; CALL_PUSH and RET_POP SHALL be ignored; RS_DEPTH, RS_FULL, RS_OVF and RS_UNF SHALL be tied to 0 and RS_EMPTY tied to 1.

Verification
REQ-034 Reset, then PC_INC for 3 cycles -> PC_COUNT 0x001, 0x002, 0x003; PC_INC at 0x3FF -> 0x000.
REQ-035 PC_LD=1, PC_INC=1, sel=00, FROM_IMMED=0x155 -> PC_COUNT=0x155; the next cycle with sel=10 -> 0x3FF.
REQ-036 HOLD=1 with PC_LD, PC_INC and CALL_PUSH all asserted -> PC_COUNT and RS_DEPTH unchanged; then RST=1 with HOLD=1 -> PC_COUNT=0x000.
REQ-037 Macro on: at PC=0x020, CALL_PUSH + PC_LD, sel=00, IMMED=0x100 -> PC=0x100, RS_DEPTH=1; then RET_POP + PC_LD, sel=01 -> PC=0x021, RS_DEPTH=0.
REQ-038 Macro on: 9 pushes with STACK_DEPTH=8 -> RS_FULL=1, RS_OVF=1, RS_DEPTH=8; then 9 pops -> RS_UNF=1, RS_DEPTH=0, and the last pop loads 0x000.
REQ-039 Macro off: sel=01, PC_LD, FROM_STACK=0x0AB -> PC=0x0AB; CALL_PUSH -> RS_DEPTH stays 0.
